// File: rtl/cv32e40p_rf_checkpoint_sequencer.sv
// rtl/cv32e40p_rf_checkpoint_sequencer.sv - GPR shadow and setback/restore/PC recovery sequencer
module cv32e40p_rf_checkpoint_sequencer #(
  parameter int NUM_REGS = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        capture_en_i,
  input  logic        core_regfile_we_a_i,
  input  logic        core_regfile_we_b_i,
  input  logic [5:0]  core_regfile_waddr_a_i,
  input  logic [5:0]  core_regfile_waddr_b_i,
  input  logic [31:0] core_regfile_wdata_a_i,
  input  logic [31:0] core_regfile_wdata_b_i,
  input  logic [31:0] core_backup_pc_i,
  input  logic        core_backup_branch_i,
  input  logic [31:0] core_backup_branch_addr_i,
  input  logic        recovery_req_i,
  output logic        recovery_busy_o,
  output logic        recovery_done_o,
  output logic        setback_o,
  output logic        recover_o,
  output logic        regfile_we_a_o,
  output logic        regfile_we_b_o,
  output logic [5:0]  regfile_waddr_a_o,
  output logic [5:0]  regfile_waddr_b_o,
  output logic [31:0] regfile_wdata_a_o,
  output logic [31:0] regfile_wdata_b_o,
  output logic        pc_recover_o,
  output logic [31:0] recovery_program_counter_o,
  output logic        recovery_branch_o,
  output logic [31:0] recovery_branch_addr_o
);

  localparam int HALF = NUM_REGS / 2;
  localparam int IDX_W = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;
  localparam logic [3:0] LAST = 4'(HALF - 1);

  typedef enum logic [1:0] {IDLE, SETBACK, RESTORE, PC} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [31:0] shadow [NUM_REGS];
  logic [31:0] pc_q;
  logic        branch_q;
  logic [31:0] branch_addr_q;
  logic        capture;
  logic [IDX_W-1:0] idx_a;
  logic [IDX_W-1:0] idx_b;

  // Shadow only tracks the core while idle, so recovery restores a frozen snapshot
  assign capture = (state == IDLE) && capture_en_i;
  assign idx_a   = IDX_W'({cnt, 1'b0});
  assign idx_b   = IDX_W'({cnt, 1'b1});

  assign recovery_program_counter_o = pc_q;
  assign recovery_branch_o          = branch_q;
  assign recovery_branch_addr_o     = branch_addr_q;

  // State register and restore pair counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == RESTORE && cnt != LAST) cnt <= cnt + 4'd1;
      else                                 cnt <= '0;
    end
  end

  // Latch the core PC/branch backup on request acceptance; held until the next one
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q          <= '0;
      branch_q      <= 1'b0;
      branch_addr_q <= '0;
    end else if (state == IDLE && recovery_req_i) begin
      pc_q          <= core_backup_pc_i;
      branch_q      <= core_backup_branch_i;
      branch_addr_q <= core_backup_branch_addr_i;
    end
  end

  // Shadow register file; entry 0 is never written, port B wins address collisions
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
    end else if (capture) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (core_regfile_we_b_i && core_regfile_waddr_b_i == 6'(i))
          shadow[i] <= core_regfile_wdata_b_i;
        else if (core_regfile_we_a_i && core_regfile_waddr_a_i == 6'(i))
          shadow[i] <= core_regfile_wdata_a_i;
      end
    end
  end

  // Next-state and decoded outputs; restore port values are zero outside RESTORE
  always_comb begin
    state_nxt         = state;
    recovery_busy_o   = 1'b0;
    recovery_done_o   = 1'b0;
    setback_o         = 1'b0;
    recover_o         = 1'b0;
    pc_recover_o      = 1'b0;
    regfile_we_a_o    = 1'b0;
    regfile_we_b_o    = 1'b0;
    regfile_waddr_a_o = '0;
    regfile_waddr_b_o = '0;
    regfile_wdata_a_o = '0;
    regfile_wdata_b_o = '0;
    case (state)
      IDLE: begin
        if (recovery_req_i) state_nxt = SETBACK;
      end
      SETBACK: begin
        recovery_busy_o = 1'b1;
        setback_o       = 1'b1;
        state_nxt       = RESTORE;
      end
      RESTORE: begin
        recovery_busy_o   = 1'b1;
        recover_o         = 1'b1;
        regfile_we_a_o    = (cnt != 4'd0);
        regfile_we_b_o    = 1'b1;
        regfile_waddr_a_o = {1'b0, cnt, 1'b0};
        regfile_waddr_b_o = {1'b0, cnt, 1'b1};
        regfile_wdata_a_o = (cnt == 4'd0) ? 32'd0 : shadow[idx_a];
        regfile_wdata_b_o = shadow[idx_b];
        if (cnt == LAST) state_nxt = PC;
      end
      PC: begin
        recovery_busy_o = 1'b1;
        recover_o       = 1'b1;
        pc_recover_o    = 1'b1;
        recovery_done_o = 1'b1;
        state_nxt       = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/cv32e40p_rf_checkpoint_sequencer.md
CV32E40P_RF_CHECKPOINT_SEQUENCER -- requirements
Module: cv32e40p_rf_checkpoint_sequencer

Interface
REQ-001 Parameter: NUM_REGS, default 32, number of GPRs shadowed and restored; SHALL be even and in the range 2..32.
REQ-002 clk_i  input  1  core clock; all state SHALL be sampled on its rising edge.
REQ-003 rst_ni  input  1  asynchronous active-low reset.
REQ-004 capture_en_i  input  1  enables shadow update from the core writeback stream.
REQ-005 core_regfile_we_a_i / core_regfile_we_b_i  input  1 each  core RF write enables, ports A and B.
REQ-006 core_regfile_waddr_a_i / core_regfile_waddr_b_i  input  6 each  core RF write addresses.
REQ-007 core_regfile_wdata_a_i / core_regfile_wdata_b_i  input  32 each  core RF write data.
REQ-008 core_backup_pc_i  input  32  core program-counter backup.
REQ-009 core_backup_branch_i  input  1  core pending-branch flag.
REQ-010 core_backup_branch_addr_i  input  32  core pending-branch target.
REQ-011 recovery_req_i  input  1  request to start recovery; level-sampled.
REQ-012 recovery_busy_o  output  1  sequence in progress.
REQ-013 recovery_done_o  output  1  one-cycle completion pulse.
REQ-014 setback_o  output  1  drives core setback_i.
REQ-015 recover_o  output  1  drives core recover_i.
REQ-016 regfile_we_a_o / regfile_we_b_o  output  1 each  restore write enables to the core.
REQ-017 regfile_waddr_a_o / regfile_waddr_b_o  output  6 each  restore write addresses.
REQ-018 regfile_wdata_a_o / regfile_wdata_b_o  output  32 each  restore write data.
REQ-019 pc_recover_o  output  1  drives core pc_recover_i.
REQ-020 recovery_program_counter_o / recovery_branch_o / recovery_branch_addr_o  output  32/1/32  restore PC, branch flag and branch target.

Function
REQ-021 Shadow: NUM_REGS x 32-bit flops. Entry 0 SHALL always read 0.
REQ-022 Shadow update rule: an entry SHALL update only in IDLE with capture_en_i=1, for we=1, waddr[5]=0, waddr<NUM_REGS and waddr!=0.
REQ-023 Same-cycle writes from A and B to one address: port B data SHALL win, matching core RF priority.
REQ-024 FSM states SHALL be IDLE, SETBACK, RESTORE, PC.
REQ-025 FSM transitions: IDLE->SETBACK when recovery_req_i=1; SETBACK->RESTORE after 1 cycle; RESTORE->PC after NUM_REGS/2 cycles; PC->IDLE after 1 cycle.
REQ-026 Request acceptance: on entering SETBACK, the block SHALL latch core_backup_pc_i, core_backup_branch_i and core_backup_branch_addr_i. recovery_req_i outside IDLE SHALL be ignored, not queued.
REQ-027 SETBACK outputs: setback_o=1, recover_o=0.
REQ-028 RESTORE sequencing: counter k = 0..NUM_REGS/2-1. recover_o=1. Port A writes reg 2k and port B writes reg 2k+1, with wdata taken from the shadow. regfile_we_a_o SHALL be 0 when 2k=0.
REQ-029 PC state outputs: recover_o=1, pc_recover_o=1, recovery_done_o=1. recovery_* outputs carry the latched values.
REQ-030 recovery_busy_o SHALL be 1 in SETBACK, RESTORE and PC.
REQ-031 Capture freeze: the shadow SHALL be frozen while busy. Core writes during recovery SHALL NOT corrupt it.
REQ-032 Outside active states: restore addr, data and we outputs SHALL be 0 outside RESTORE. Latched recovery_* values SHALL hold until the next acceptance.
REQ-033 Latency: a request sampled at edge 0 SHALL give setback_o in cycle 1, RESTORE in cycles 2..NUM_REGS/2+1, and the PC state in cycle NUM_REGS/2+2. A new request SHALL be accepted earliest at the edge ending the PC cycle +1.

Reset
REQ-034 On rst_ni=0, asynchronously: FSM->IDLE, counter=0, shadow=0, latched PC/branch=0, all outputs=0. This applies mid-sequence too.
REQ-035 After reset release, the block SHALL be in IDLE with capture active as gated by capture_en_i.

Verification
REQ-036 capture_en_i=1, A writes x5=0xDEADBEEF, then recovery_req_i pulse -> setback_o=1 for 1 cycle; in RESTORE cycle k=2, waddr_b_o=5, wdata_b_o=0xDEADBEEF.
REQ-037 Same-cycle A and B writes to x7 (A=0x1111_1111, B=0x2222_2222) -> restored x7=0x2222_2222.
REQ-038 Writes to x0 and to addr 32 (waddr[5]=1), then recovery -> cycle k=0 has we_a_o=0; no shadow change observed.
REQ-039 core_backup_pc_i=0x0000_1A40, branch=1, addr=0x0000_2000 at acceptance; inputs changed afterwards -> PC cycle (cycle 18 for NUM_REGS=32) shows pc_recover_o=1, done=1, recovery_program_counter_o=0x1A40, recovery_branch_o=1, recovery_branch_addr_o=0x2000.
REQ-040 recovery_req_i held high plus core writes during RESTORE -> no re-entry before IDLE and the shadow is unchanged; a second sequence starts one cycle after the PC state.
REQ-041 rst_ni asserted at RESTORE k=5 -> all outputs 0 immediately, busy=0; a subsequent recovery restores all zeros.
